// File: rtl/shifter_pkg.sv
// Shared opcodes, default widths and the per-stage payload of the pipelined barrel shifter.
// Build macro SHIFTER_ROTATE_EN enables the rotate-right datapath in every stage.
package shifter_pkg;

    localparam int unsigned PKG_WIDTH   = 32;
    localparam int unsigned PKG_TAG_W   = 5;
    localparam int unsigned PKG_SHAMT_W = $clog2(PKG_WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Everything one stage hands to the next; sign is the operand MSB captured on entry.
    typedef struct packed {
        logic [PKG_WIDTH-1:0]   data;
        logic [PKG_SHAMT_W-1:0] shamt;
        logic [1:0]             op;
        logic                   sign;
        logic [PKG_TAG_W-1:0]   tag;
    } stage_t;

endpackage

// File: rtl/shift_stage.sv
// One logarithmic shift level: conditionally shifts by DIST, then registers the payload.
// Rotate handling is present only when SHIFTER_ROTATE_EN is defined; otherwise ROR acts as SRL.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned DIST = 1,
    parameter int unsigned BIT  = 0
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   up_valid,
    input  stage_t up_pay,
    input  logic   dn_load,
    output logic   load_c,
    output logic   valid,
    output stage_t pay
);

    logic                 valid_q, valid_d;
    stage_t               pay_q, pay_d;
    logic [PKG_WIDTH-1:0] shifted_c;

    // Stage accepts new contents when empty or when its own contents move downstream.
    assign load_c = !valid_q || dn_load;

    always_comb begin
        shifted_c = up_pay.data;
        if (up_pay.shamt[BIT]) begin
            case (up_pay.op)
                OP_SLL:  shifted_c = up_pay.data << DIST;
                OP_SRA:  shifted_c = (up_pay.data >> DIST)
                                   | ({PKG_WIDTH{up_pay.sign}} << (PKG_WIDTH - DIST));
`ifdef SHIFTER_ROTATE_EN
                OP_ROR:  shifted_c = (up_pay.data >> DIST)
                                   | (up_pay.data << (PKG_WIDTH - DIST));
`endif
                default: shifted_c = up_pay.data >> DIST;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (load_c) begin
            valid_d = up_valid;
            // Payload only changes for a real operand so idle stages keep their last value.
            if (up_valid) begin
                pay_d      = up_pay;
                pay_d.data = shifted_c;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign valid = valid_q;
    assign pay   = pay_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SHAMT_W shift stages with a combinational ready chain and full backpressure.
// Build macro SHIFTER_ROTATE_EN selects rotate-right for op 11; without it op 11 executes as SRL.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = PKG_WIDTH,
    parameter int unsigned TAG_W   = PKG_TAG_W,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    stage_t in_pay_c;
    stage_t pay_c   [SHAMT_W];
    logic   valid_c [SHAMT_W];
    logic   load_c  [SHAMT_W];
    logic   unused_last_fields;

    always_comb begin
        in_pay_c       = '0;
        in_pay_c.data  = in_data;
        in_pay_c.shamt = in_shamt;
        in_pay_c.op    = in_op;
        in_pay_c.sign  = in_data[WIDTH-1];
        in_pay_c.tag   = in_tag;
    end

    // Stage k shifts by WIDTH>>(k+1) under control of shamt bit SHAMT_W-1-k.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic   up_valid_c;
        stage_t up_pay_c;
        logic   dn_load_c;

        if (k == 0) begin : g_head
            assign up_valid_c = in_valid;
            assign up_pay_c   = in_pay_c;
        end else begin : g_body
            assign up_valid_c = valid_c[k-1];
            assign up_pay_c   = pay_c[k-1];
        end

        if (k == SHAMT_W - 1) begin : g_tail
            assign dn_load_c = !valid_c[k] || out_ready;
        end else begin : g_mid
            assign dn_load_c = load_c[k+1];
        end

        shift_stage #(
            .DIST (WIDTH >> (k + 1)),
            .BIT  (SHAMT_W - 1 - k)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .up_valid (up_valid_c),
            .up_pay   (up_pay_c),
            .dn_load  (dn_load_c),
            .load_c   (load_c[k]),
            .valid    (valid_c[k]),
            .pay      (pay_c[k])
        );
    end

    assign in_ready  = load_c[0];
    assign out_valid = valid_c[SHAMT_W-1];
    assign out_data  = pay_c[SHAMT_W-1].data;
    assign out_tag   = pay_c[SHAMT_W-1].tag;

    assign unused_last_fields = ^{pay_c[SHAMT_W-1].shamt, pay_c[SHAMT_W-1].op,
                                  pay_c[SHAMT_W-1].sign};

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter for the processor's execute stage. It replaces the fixed-amount shift blocks with a single unit. The unit takes a WIDTH-bit operand, a shift amount and an opcode, and applies one logarithmic shift level per pipeline stage. Results emerge after a fixed latency through a valid/ready handshake with full backpressure, and a writeback tag travels with each operand.

## Interface
- WIDTH, 32, operand width; power of two, ≥ 4
- TAG_W, 5, width of the sideband tag (destination register index)
- SHAMT_W (localparam), $clog2(WIDTH), shift-amount width and pipeline depth
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; clears all pipeline valid bits
- in_valid  input  1  operand presented
- in_ready  output  1  unit can accept this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_op  input  2  opcode: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- in_tag  input  TAG_W  sideband tag, passed through unchanged
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result this cycle
- out_data  output  WIDTH  shifted result
- out_tag  output  TAG_W  tag of the result

## Operation
- SHAMT_W stages, indexed 0..SHAMT_W-1. Stage k applies a shift of WIDTH>>(k+1) when shamt bit (SHAMT_W-1-k) is set, then registers the data, remaining shamt, op, tag and a valid bit.
- SLL: zero fill from the LSB. SRL: zero fill from the MSB. SRA: fill with the operand's original bit WIDTH-1, carried from stage 0. ROR: bits shifted out of the LSB re-enter at the MSB.
- Shamt 0: the result equals the operand for every op.
- Stage k loads when valid_k is 0 or stage k+1 loads. The last stage loads when out_valid is 0 or out_ready is 1.
- in_ready equals the stage-0 load condition. This ready chain is combinational.
- A transfer occurs only when valid and ready are both high in the same cycle. The producer holds its inputs stable until accepted.
- out_valid = valid of the last stage. out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- A stage that does not load holds all its fields.

## Timing
- Reset: all valid bits are 0, so out_valid=0. in_ready=1 in the first cycle after reset. out_data=0 and out_tag=0 after reset.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+SHAMT_W-1, i.e. SHAMT_W registered stages. For WIDTH=32 that is 5 stages.
- Throughput: one result per cycle while out_ready=1.
- Full pipe with out_ready=0: in_ready=0 and nothing moves. Bubbles in the pipe compress forward even while the output is stalled.
- Simultaneous accept and emit: both transfers complete in the same cycle, with no bubble inserted.
- Reset mid-operation: all in-flight operands are discarded. Nothing is emitted from them after reset deasserts.

## Configuration
- SHIFTER_ROTATE_EN defined: op 11 performs a rotate right, and the wrap-around mux is present in each stage.
- SHIFTER_ROTATE_EN undefined: the rotate logic is removed and op 11 executes as SRL. Handshake and latency are unchanged.

## Structure
- Package shifter_pkg holds the opcode constants OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10 and OP_ROR=2'b11, plus a stage-payload struct (data, shamt, op, sign, tag).
- Sub-module shift_stage implements one shift level with its register and load logic. It is parametrised by the shift distance and instantiated SHAMT_W times with generate.
- The top level contains only the stage chain, the ready chain and the output assignments.

## Test plan
- WIDTH=32, SRA 0x80000000 by 16 -> out_data 0xFFFF8000 five cycles after accept; SRL on the same operand -> 0x00008000.
- SLL 0x00000001 by 31 -> 0x80000000; shamt 0 for each op on 0xDEADBEEF -> 0xDEADBEEF with the tag unchanged.
- ROR 0x00000001 by 1 -> 0x80000000 with SHIFTER_ROTATE_EN defined, and 0x00000000 without it.
- Stream 8 random operands with tags 0..7 while holding out_ready=0 for 10 cycles. Then:
  - in_ready must fall after 5 accepts;
  - results must drain in order with correct tags;
  - no result may be lost or duplicated.
- Random valid/ready toggling over 10,000 operations, checked against a reference model: throughput is 1 per cycle when out_ready is held at 1, and every result matches.
- Assert reset with 3 operands in flight: out_valid=0 on the next cycle and in_ready=1. Only operands accepted after reset are emitted.
